stack_value_display: RTL

Downstream display stage for the stack processor. Accepts a binary stack-top value with a load strobe, converts it to decimal with a sequential double-dabble converter, and holds the result in a display register. A multiplexed scanner then presents one decimal digit per scan slot on a `digit`/`valid` pair that drives `seven_seg`, together with a one-hot digit-select bus for the common anodes. Width overflow and empty-stack (invalid) values display as "-".

---
 rtl/stack_display_pkg.sv | 16 +
 rtl/bcd_double_dabble.sv | 115 +++++++++++
 rtl/stack_value_display.sv | 128 ++++++++++++
 3 files changed

// File: rtl/stack_display_pkg.sv
// Shared types and widths for the stack value display path.
//   state_e     : converter FSM states
//   BCD_W       : bits per decimal digit
//   SEG_DIGIT_W : width of the seven_seg digit port
package stack_display_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_e;

    localparam int unsigned BCD_W       = 4;
    localparam int unsigned SEG_DIGIT_W = 5;

endpackage

// File: rtl/bcd_double_dabble.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   load              : start conversion (taken only when ready)
//   value, value_valid: operand and its validity, captured on load
//   ready             : idle, a load is accepted this cycle
//   done              : high for the single COMMIT cycle; results are stable
//   bcd, bcd_valid    : converted digits and captured validity
//   bcd_ovf           : value did not fit in DIGITS decimal digits
module bcd_double_dabble
    import stack_display_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [WIDTH-1:0]          value,
    input  logic                      value_valid,
    output logic                      ready,
    output logic                      done,
    output logic [DIGITS*BCD_W-1:0]   bcd,
    output logic                      bcd_valid,
    output logic                      bcd_ovf
);

    localparam int unsigned BCD_BITS = DIGITS * BCD_W;
    localparam int unsigned CNT_W    = $clog2(WIDTH + 1);

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      shift_q, shift_d;
    logic [BCD_BITS-1:0]   bcd_q, bcd_d;
    logic [BCD_BITS-1:0]   corr;
    logic                  pend_valid_q, pend_valid_d;
    logic                  ovf_q, ovf_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;

    // Add-3 correction on every digit >= 5 before each shift.
    always_comb begin
        corr = bcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[i*BCD_W +: BCD_W] >= 4'd5) begin
                corr[i*BCD_W +: BCD_W] = bcd_q[i*BCD_W +: BCD_W] + 4'd3;
            end
        end
    end

    // Next-state and datapath.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bcd_d        = bcd_q;
        pend_valid_d = pend_valid_q;
        ovf_d        = ovf_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    shift_d      = value;
                    pend_valid_d = value_valid;
                    bcd_d        = '0;
                    ovf_d        = 1'b0;
                    cnt_d        = '0;
                    state_d      = CONVERT;
                end
            end
            CONVERT: begin
                bcd_d   = {corr[BCD_BITS-2:0], shift_q[WIDTH-1]};
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                // A bit leaving the top digit means the value needs more digits.
                ovf_d   = ovf_q | corr[BCD_BITS-1];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        done_d  = (state_d == COMMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bcd_q        <= '0;
            pend_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            cnt_q        <= '0;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bcd_q        <= bcd_d;
            pend_valid_q <= pend_valid_d;
            ovf_q        <= ovf_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign bcd       = bcd_q;
    assign bcd_valid = pend_valid_q;
    assign bcd_ovf   = ovf_q;

endmodule

// File: rtl/stack_value_display.sv
// Stack-top value display: converts to decimal, latches the result and scans
// one digit per slot out to a seven-segment decoder.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   value, value_valid     : value to display and its validity (0 = empty stack)
//   load / ready           : conversion request / converter idle
//   scan_digit, scan_valid : current slot digit for seven_seg (registered)
//   digit_sel              : one-hot anode select for the current slot (registered)
// Build option: STACK_DISPLAY_LZ_BLANK_EN enables leading-zero blanking.
module stack_value_display
    import stack_display_pkg::*;
#(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned SCAN_DIV_BITS = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       value,
    input  logic                   value_valid,
    input  logic                   load,
    output logic                   ready,
    output logic [SEG_DIGIT_W-1:0] scan_digit,
    output logic                   scan_valid,
    output logic [DIGITS-1:0]      digit_sel
);

    localparam int unsigned BCD_BITS = DIGITS * BCD_W;
    localparam int unsigned SLOT_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                     conv_done;
    logic [BCD_BITS-1:0]      conv_bcd;
    logic                     conv_valid;
    logic                     conv_ovf;

    logic [BCD_BITS-1:0]      disp_digits_q, disp_digits_d;
    logic                     disp_valid_q, disp_valid_d;
    logic                     disp_ovf_q, disp_ovf_d;
    logic [SCAN_DIV_BITS-1:0] presc_q, presc_d;
    logic [SLOT_W-1:0]        slot_q, slot_d;
    logic [SEG_DIGIT_W-1:0]   scan_digit_q, scan_digit_d;
    logic                     scan_valid_q, scan_valid_d;
    logic [DIGITS-1:0]        digit_sel_q, digit_sel_d;
    logic                     show_c;

    bcd_double_dabble #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .value       (value),
        .value_valid (value_valid),
        .ready       (ready),
        .done        (conv_done),
        .bcd         (conv_bcd),
        .bcd_valid   (conv_valid),
        .bcd_ovf     (conv_ovf)
    );

    assign show_c = disp_valid_q & ~disp_ovf_q;

    // Display register, scan timing and per-slot outputs.
    always_comb begin
        disp_digits_d = disp_digits_q;
        disp_valid_d  = disp_valid_q;
        disp_ovf_d    = disp_ovf_q;
        if (conv_done) begin
            disp_digits_d = conv_bcd;
            disp_valid_d  = conv_valid;
            disp_ovf_d    = conv_ovf;
        end

        presc_d = presc_q + SCAN_DIV_BITS'(1);
        slot_d  = slot_q;
        if (&presc_q) begin
            slot_d = (slot_q == SLOT_W'(DIGITS - 1)) ? '0 : slot_q + SLOT_W'(1);
        end

        digit_sel_d  = DIGITS'(1) << slot_q;
        scan_digit_d = SEG_DIGIT_W'(disp_digits_q[int'(slot_q)*BCD_W +: BCD_W]);
        scan_valid_d = show_c;

`ifdef STACK_DISPLAY_LZ_BLANK_EN
        // Anode off above the most significant nonzero digit of a valid result.
        begin
            logic [SLOT_W-1:0] msd;
            msd = '0;
            for (int i = 1; i < int'(DIGITS); i++) begin
                if (disp_digits_q[i*BCD_W +: BCD_W] != '0) begin
                    msd = SLOT_W'(i);
                end
            end
            if (show_c && (slot_q > msd)) begin
                digit_sel_d = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_digits_q <= '0;
            disp_valid_q  <= 1'b0;
            disp_ovf_q    <= 1'b0;
            presc_q       <= '0;
            slot_q        <= '0;
            scan_digit_q  <= '0;
            scan_valid_q  <= 1'b0;
            digit_sel_q   <= '0;
        end else begin
            disp_digits_q <= disp_digits_d;
            disp_valid_q  <= disp_valid_d;
            disp_ovf_q    <= disp_ovf_d;
            presc_q       <= presc_d;
            slot_q        <= slot_d;
            scan_digit_q  <= scan_digit_d;
            scan_valid_q  <= scan_valid_d;
            digit_sel_q   <= digit_sel_d;
        end
    end

    assign scan_digit = scan_digit_q;
    assign scan_valid = scan_valid_q;
    assign digit_sel  = digit_sel_q;

endmodule
